// File: rtl/conv1_dataflow_ctrl.sv
// conv1_dataflow_ctrl: fans one ap_ctrl_hs start out to N_PROC processes, caps in-flight iterations, buffers sink done, watches for stalls
module conv1_dataflow_ctrl #(
  parameter int N_PROC       = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 4,
  parameter int STALL_LIMIT  = 4096,
  parameter int STALL_W      = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic [N_PROC-1:0] proc_start,
  input  logic [N_PROC-1:0] proc_ready,
  input  logic [N_PROC-1:0] proc_idle,
  input  logic              proc_done,
  output logic              proc_continue,
  output logic [CNT_W-1:0]  inflight,
  output logic [1:0]        state,
  output logic              stall_flag,
  input  logic              stall_clr
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_STALL = 2'd3;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [STALL_W-1:0] LIM = STALL_W'(STALL_LIMIT);
  logic [N_PROC-1:0]  rdy_latch_q, rdy_latch_d;
  logic               done_hold_q, done_hold_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_flag_q, stall_flag_d;
  logic [1:0]         state_q, state_d;
  logic               start_en, done_acc, progress, cnt_rst, stall_set;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rdy_latch_q  <= '0;
      done_hold_q  <= 1'b0;
      inflight_q   <= '0;
      stall_cnt_q  <= '0;
      stall_flag_q <= 1'b0;
    end else begin
      rdy_latch_q  <= rdy_latch_d;
      done_hold_q  <= done_hold_d;
      inflight_q   <= inflight_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_flag_q <= stall_flag_d;
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    start_en      = ap_start & (inflight_q < MAX_CNT) & (state_q != S_STALL);
    proc_start    = {N_PROC{start_en}} & ~rdy_latch_q;
    ap_ready      = start_en & (&(rdy_latch_q | proc_ready));
    rdy_latch_d   = ap_ready ? '0 : rdy_latch_q | (proc_start & proc_ready);
    ap_done       = done_hold_q | proc_done;
    proc_continue = ~done_hold_q;
    done_acc      = ap_done & ap_continue;
    done_hold_d   = (done_hold_q | proc_done) & ~ap_continue;
    inflight_d    = (ap_ready & ~done_acc) ? inflight_q + 1'b1 :
                    (done_acc & ~ap_ready & (inflight_q != '0)) ? inflight_q - 1'b1 : inflight_q;
    ap_idle       = (inflight_q == '0) & (&proc_idle) & ~done_hold_q;
    progress      = (|(proc_start & proc_ready)) | proc_done;
    cnt_rst       = progress | stall_clr | (inflight_q == '0);
    stall_cnt_d   = cnt_rst ? '0 : (stall_cnt_q == LIM) ? stall_cnt_q : stall_cnt_q + 1'b1;
    stall_set     = ~cnt_rst & (stall_cnt_q == LIM - 1'b1);
    stall_flag_d  = ~stall_clr & (stall_flag_q | stall_set);
    inflight      = inflight_q;
    state         = state_q;
    stall_flag    = stall_flag_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = ap_ready ? S_RUN : S_IDLE;
      S_RUN:   state_d = ap_start ? S_RUN : (inflight_d != '0) ? S_DRAIN : S_IDLE;
      S_DRAIN: state_d = ap_ready ? S_RUN : (inflight_d == '0) ? S_IDLE : S_DRAIN;
      default: state_d = stall_clr ? S_IDLE : S_STALL;
    endcase
    if (stall_set && state_q != S_STALL) state_d = S_STALL;
  end
endmodule

// File: tb/tb_conv1_dataflow_ctrl.sv
// tb_conv1_dataflow_ctrl: directed scenarios with an ap_ready scoreboard for conv1_dataflow_ctrl
module tb_conv1_dataflow_ctrl;
  localparam int N = 4;
  logic clock = 1'b0, reset = 1'b0, ap_start = 1'b0, ap_continue = 1'b0, proc_done = 1'b0, stall_clr = 1'b0;
  logic [N-1:0] proc_ready = '0, proc_idle = '1;
  logic ap_ready, ap_done, ap_idle, proc_continue, stall_flag;
  logic [N-1:0] proc_start;
  logic [3:0] inflight;
  logic [1:0] state;
  int n_chk = 0, n_pass = 0;
  int exp_q[$];
  int rc[N];
  always #5 clock = ~clock;
  conv1_dataflow_ctrl #(.N_PROC(N), .MAX_INFLIGHT(2), .CNT_W(4), .STALL_LIMIT(16), .STALL_W(5)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .ap_idle(ap_idle), .proc_start(proc_start), .proc_ready(proc_ready),
    .proc_idle(proc_idle), .proc_done(proc_done), .proc_continue(proc_continue), .inflight(inflight),
    .state(state), .stall_flag(stall_flag), .stall_clr(stall_clr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic cyc;
    @(posedge clock);
    #1;
  endtask
  always @(negedge clock)
    if (reset && ap_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_ready", 32'(ap_ready), 0);
      else chk("sb_ready_inflight", 32'(inflight), 32'(exp_q.pop_front()));
    end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    logic [N-1:0] exp_ps;
    rc = '{1, 3, 3, 5};
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_flag", 32'(stall_flag), 0);
    chk("rst_proc_start", 32'(proc_start), 0);
    chk("rst_ap_ready", 32'(ap_ready), 0);
    chk("rst_proc_cont", 32'(proc_continue), 1);
    chk("rst_ap_idle", 32'(ap_idle), 1);
    proc_done = 1'b1;
    #1;
    chk("rst_ap_done", 32'(ap_done), 1);
    proc_done = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      cyc();
      ap_start = 1'b1;
      for (int i = 0; i < N; i++) proc_ready[i] = (c == rc[i]);
      if (c == 5) exp_q.push_back(0);
      #1;
      for (int i = 0; i < N; i++) exp_ps[i] = (c <= rc[i]);
      chk("t1_proc_start", 32'(proc_start), 32'(exp_ps));
      chk("t1_ap_ready", 32'(ap_ready), 32'(c == 5));
      chk("t1_state_idle", 32'(state), 0);
    end
    cyc();
    ap_start = 1'b0;
    proc_ready = '0;
    #1;
    chk("t1_inflight", 32'(inflight), 1);
    chk("t1_state_run", 32'(state), 1);
    chk("t1_start_off", 32'(proc_start), 0);
    cyc();
    #1;
    chk("t1_state_drain", 32'(state), 2);
    cyc();
    ap_start = 1'b1;
    proc_ready = '1;
    exp_q.push_back(1);
    #1;
    chk("t2_ready2", 32'(ap_ready), 1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      #1;
      chk("t2_cap_start", 32'(proc_start), 0);
      chk("t2_cap_ready", 32'(ap_ready), 0);
      chk("t2_cap_inflight", 32'(inflight), 2);
    end
    cyc();
    proc_done = 1'b1;
    ap_continue = 1'b1;
    #1;
    chk("t2_done", 32'(ap_done), 1);
    chk("t2_no_ready", 32'(ap_ready), 0);
    cyc();
    proc_done = 1'b0;
    ap_continue = 1'b0;
    exp_q.push_back(1);
    #1;
    chk("t2_inflight_dec", 32'(inflight), 1);
    chk("t2_ready3", 32'(ap_ready), 1);
    for (int c = 0; c <= 5; c++) begin
      cyc();
      ap_start = 1'b0;
      proc_ready = '0;
      proc_done = (c == 0);
      ap_continue = (c == 4);
      #1;
      chk("t3_ap_done", 32'(ap_done), 32'(c <= 4));
      chk("t3_proc_cont", 32'(proc_continue), 32'(c == 0 || c == 5));
      chk("t3_inflight", 32'(inflight), (c <= 4) ? 2 : 1);
      if (c == 2) chk("t3_not_idle", 32'(ap_idle), 0);
    end
    chk("t3_state_drain", 32'(state), 2);
    cyc();
    ap_start = 1'b1;
    proc_ready = '1;
    proc_done = 1'b1;
    ap_continue = 1'b1;
    exp_q.push_back(1);
    #1;
    chk("t4_ready", 32'(ap_ready), 1);
    chk("t4_done", 32'(ap_done), 1);
    cyc();
    proc_ready = '0;
    proc_done = 1'b0;
    ap_continue = 1'b0;
    #1;
    chk("t4_inflight", 32'(inflight), 1);
    chk("t4_state_run", 32'(state), 1);
    chk("t4_start_en", 32'(proc_start), 32'hF);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      #1;
      chk("t5_flag", 32'(stall_flag), 32'(k == 16));
      chk("t5_state", 32'(state), (k == 16) ? 3 : 1);
      chk("t5_proc_start", 32'(proc_start), (k == 16) ? 0 : 32'hF);
    end
    cyc();
    stall_clr = 1'b1;
    #1;
    chk("t5_stall_hold", 32'(state), 3);
    cyc();
    stall_clr = 1'b0;
    proc_ready = 4'b0101;
    #1;
    chk("t5_clr_flag", 32'(stall_flag), 0);
    chk("t5_clr_state", 32'(state), 0);
    cyc();
    proc_ready = '0;
    #1;
    chk("t6_latched", 32'(proc_start), 32'hA);
    #2;
    reset = 1'b0;
    ap_start = 1'b0;
    #1;
    chk("t6_inflight", 32'(inflight), 0);
    chk("t6_state", 32'(state), 0);
    chk("t6_flag", 32'(stall_flag), 0);
    chk("t6_proc_start", 32'(proc_start), 0);
    chk("t6_proc_cont", 32'(proc_continue), 1);
    chk("t6_idle_hi", 32'(ap_idle), 1);
    proc_idle = 4'b1110;
    #1;
    chk("t6_idle_lo", 32'(ap_idle), 0);
    proc_idle = '1;
    cyc();
    reset = 1'b1;
    ap_start = 1'b1;
    #1;
    chk("t6_latch_cleared", 32'(proc_start), 32'hF);
    chk("sb_empty", 32'(exp_q.size()), 0);
    ap_start = 1'b0;
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
